// File: rtl/calkko_core.sv
// 4-digit BCD calculator datapath: sanitised operand display, BCD add/sub and per-digit
// logic ops, all registered with one cycle of latency.
module calkko_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  A1,
  input  logic [3:0]  A2,
  input  logic [3:0]  A3,
  input  logic [3:0]  A4,
  input  logic [3:0]  B1,
  input  logic [3:0]  B2,
  input  logic [3:0]  B3,
  input  logic [3:0]  B4,
  input  logic [1:0]  ST,
  input  logic [2:0]  ST_L,
  output logic        set,
  output logic [15:0] number
);

  typedef enum logic [1:0] {
    StA   = 2'd0,
    StB   = 2'd1,
    StObl = 2'd2,
    StWyn = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpXor = 3'd2,
    OpOr  = 3'd3,
    OpAnd = 3'd4
  } op_e;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  logic [15:0] a_san, b_san;
  logic [15:0] sum_bcd, diff_bcd;
  logic [15:0] number_d, number_q;
  logic        set_d, set_q;

  assign a_san = {clamp9(A1), clamp9(A2), clamp9(A3), clamp9(A4)};
  assign b_san = {clamp9(B1), clamp9(B2), clamp9(B3), clamp9(B4)};

  // Ripple carry/borrow from units (nibble 0) up to thousands; final carry/borrow dropped.
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [4:0] s;
    logic [4:0] t;
    carry    = 1'b0;
    borrow   = 1'b0;
    s        = 5'd0;
    t        = 5'd0;
    sum_bcd  = 16'h0000;
    diff_bcd = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a_san[i*4 +: 4]} + {1'b0, b_san[i*4 +: 4]} + {4'd0, carry};
      if (s > 5'd9) begin
        s     = s - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum_bcd[i*4 +: 4] = s[3:0];

      // Biased by 10 so the intermediate never goes negative.
      t = {1'b0, a_san[i*4 +: 4]} + 5'd10 - {1'b0, b_san[i*4 +: 4]} - {4'd0, borrow};
      if (t < 5'd10) begin
        borrow = 1'b1;
      end else begin
        t      = t - 5'd10;
        borrow = 1'b0;
      end
      diff_bcd[i*4 +: 4] = t[3:0];
    end
  end

  always_comb begin
    number_d = number_q;
    set_d    = set_q;
    unique case (state_e'(ST))
      StA: begin
        number_d = a_san;
        set_d    = 1'b0;
      end
      StB: begin
        number_d = b_san;
        set_d    = 1'b0;
      end
      StObl: begin
        set_d = 1'b1;
        case (ST_L)
          OpAdd:   number_d = sum_bcd;
          OpSub:   number_d = diff_bcd;
          OpXor:   number_d = a_san ^ b_san;
          OpOr:    number_d = a_san | b_san;
          OpAnd:   number_d = a_san & b_san;
          default: begin
            number_d = 16'h0000;
            set_d    = 1'b0;
          end
        endcase
      end
      StWyn: begin
        number_d = number_q;
        set_d    = set_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      number_q <= 16'h0000;
      set_q    <= 1'b0;
    end else begin
      number_q <= number_d;
      set_q    <= set_d;
    end
  end

  assign number = number_q;
  assign set    = set_q;

endmodule

// File: tb/tb_calkko_core.sv
// Scoreboard bench for calkko_core: an integer-arithmetic reference model queues the expected
// {set, number} when each vector is driven; it is popped and compared after the next edge.
module tb_calkko_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  A1, A2, A3, A4, B1, B2, B3, B4;
  logic [1:0]  ST;
  logic [2:0]  ST_L;
  logic        set;
  logic [15:0] number;

  typedef struct {
    string       tag;
    logic [16:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] m_num       = 16'h0000;
  logic        m_set       = 1'b0;

  calkko_core dut (
    .clk    (clk),
    .rst    (rst),
    .A1     (A1),
    .A2     (A2),
    .A3     (A3),
    .A4     (A4),
    .B1     (B1),
    .B2     (B2),
    .B3     (B3),
    .B4     (B4),
    .ST     (ST),
    .ST_L   (ST_L),
    .set    (set),
    .number (number)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] san16(input logic [15:0] x);
    logic [15:0] r;
    logic [3:0]  n;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      n = x[i*4 +: 4];
      r[i*4 +: 4] = (n > 4'd9) ? 4'd9 : n;
    end
    return r;
  endfunction

  function automatic int bcd2int(input logic [15:0] x);
    return int'(x[15:12]) * 1000 + int'(x[11:8]) * 100 + int'(x[7:4]) * 10 + int'(x[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got set=%b number=%h, expected set=%b number=%h",
               tag, got[16], got[15:0], exp[16], exp[15:0]);
    end
  endtask

  // Reference model of one clock edge.
  task automatic model(input logic r, input logic [1:0] st, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    logic [15:0] sa, sb;
    int          va, vb;
    sa = san16(a);
    sb = san16(b);
    va = bcd2int(sa);
    vb = bcd2int(sb);
    if (r) begin
      m_num = 16'h0000;
      m_set = 1'b0;
    end else begin
      case (st)
        2'd0: begin m_num = sa; m_set = 1'b0; end
        2'd1: begin m_num = sb; m_set = 1'b0; end
        2'd2: begin
          m_set = 1'b1;
          case (op)
            3'd0:    m_num = int2bcd((va + vb) % 10000);
            3'd1:    m_num = int2bcd((va - vb + 10000) % 10000);
            3'd2:    m_num = sa ^ sb;
            3'd3:    m_num = sa | sb;
            3'd4:    m_num = sa & sb;
            default: begin m_num = 16'h0000; m_set = 1'b0; end
          endcase
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic [1:0] st, input logic [2:0] op,
                      input logic [15:0] a, input logic [15:0] b, input string tag);
    sb_t ent;
    rst  = r;
    ST   = st;
    ST_L = op;
    {A1, A2, A3, A4} = a;
    {B1, B2, B3, B4} = b;
    model(r, st, op, a, b);
    ent.tag = tag;
    ent.exp = {m_set, m_num};
    sb_q.push_back(ent);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 17'h0, 17'h1);
    end else begin
      ent = sb_q.pop_front();
      check(ent.tag, {set, number}, ent.exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    ST   = 2'd0;
    ST_L = 3'd0;
    {A1, A2, A3, A4, B1, B2, B3, B4} = '0;
    @(negedge clk);

    step(1'b1, 2'd2, 3'd0, 16'h1234, 16'h0001, "reset");

    step(1'b0, 2'd2, 3'd0, 16'h0005, 16'h0001, "add_5_1");
    step(1'b0, 2'd2, 3'd1, 16'h0005, 16'h0001, "sub_5_1");
    step(1'b0, 2'd2, 3'd2, 16'h0005, 16'h0001, "xor_5_1");
    step(1'b0, 2'd2, 3'd3, 16'h0005, 16'h0001, "or_5_1");
    step(1'b0, 2'd2, 3'd4, 16'h0005, 16'h0001, "and_5_1");

    step(1'b0, 2'd2, 3'd0, 16'h0999, 16'h0001, "add_carry_chain");
    step(1'b0, 2'd2, 3'd0, 16'h9999, 16'h0001, "add_wrap");
    step(1'b0, 2'd2, 3'd1, 16'h1000, 16'h0001, "sub_borrow_chain");
    step(1'b0, 2'd2, 3'd1, 16'h0000, 16'h0001, "sub_underflow");
    step(1'b0, 2'd2, 3'd3, 16'h0009, 16'h0006, "or_nibble_f");

    step(1'b0, 2'd0, 3'd0, 16'h1234, 16'h0000, "show_a");
    step(1'b0, 2'd1, 3'd0, 16'h1234, 16'h5678, "show_b");
    step(1'b0, 2'd0, 3'd0, 16'h123C, 16'h0000, "show_a_clamp");
    step(1'b0, 2'd2, 3'd0, 16'hFA0B, 16'h0001, "add_clamped");

    step(1'b0, 2'd2, 3'd0, 16'h0012, 16'h0030, "add_12_30");
    step(1'b0, 2'd3, 3'd0, 16'h7777, 16'h0030, "hold_1");
    step(1'b0, 2'd3, 3'd1, 16'h0001, 16'h0002, "hold_2");
    step(1'b0, 2'd2, 3'd6, 16'h0012, 16'h0030, "reserved_op");

    step(1'b0, 2'd2, 3'd0, 16'h0012, 16'h0030, "pre_reset");
    step(1'b1, 2'd2, 3'd0, 16'h0012, 16'h0030, "mid_reset");
    step(1'b0, 2'd2, 3'd0, 16'h0012, 16'h0030, "post_reset");

    for (int i = 0; i < 60; i++) begin
      logic [1:0] st;
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      step(1'b0, st, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net against a stalled simulation.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/calkko_core.md
Name: calkko_core

Overview:
- 4-digit BCD calculator datapath for the calculator top level.
- Takes two 4-digit BCD operands (A, B), a 2-bit calculator state and a 3-bit operation select.
- Drives a registered 16-bit BCD display word plus a result-valid flag.
- One cycle of latency; no internal sequencing beyond the output registers. The controller owns ST.

Parameters:
- None. Widths fixed: 4 digits × 4 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- A1  input  4  operand A thousands digit (BCD)
- A2  input  4  operand A hundreds digit
- A3  input  4  operand A tens digit
- A4  input  4  operand A units digit
- B1  input  4  operand B thousands digit
- B2  input  4  operand B hundreds digit
- B3  input  4  operand B tens digit
- B4  input  4  operand B units digit
- ST  input  2  calculator state: 0=S_A (entering A), 1=S_B (entering B), 2=S_OBL (compute), 3=S_WYN (hold result)
- ST_L  input  3  operation: 0=SL_ADD, 1=SL_SUB, 2=SL_XOR, 3=SL_OR, 4=SL_AND, 5–7 reserved
- set  output  1  result valid
- number  output  16  display word; [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units

Behaviour:
- Reset (rst=1 at clk edge): number=16'h0000, set=0. Reset overrides all other inputs.
- All outputs are registered. Every input is sampled at a rising edge, and the result appears after that edge (1-cycle latency).
- Input sanitising: any operand digit >9 is treated as 9 before use in any state.
- ST=S_A: number <= {A1,A2,A3,A4} (sanitised); set <= 0.
- ST=S_B: number <= {B1,B2,B3,B4} (sanitised); set <= 0.
- ST=S_OBL: number <= f(A,B,ST_L); set <= 1. Recomputed every cycle, so ST_L or operand changes take effect on the next edge.
- ST=S_WYN: number and set hold their current values (no recompute).
- Operations (A, B are the 4-digit decimal values 0..9999):
  - SL_ADD: BCD add with per-digit decimal carry (digit sum >9 → subtract 10, carry 1). Result is (A+B) mod 10000; carry out of the thousands digit is discarded.
  - SL_SUB: BCD subtract with per-digit borrow. Result is (A−B) mod 10000, i.e. ten's complement on underflow (0000−0001 = 9999).
  - SL_XOR / SL_OR / SL_AND: bitwise per 4-bit digit on the sanitised digits, no decimal correction.
  - Logical ops may yield nibbles >9 (e.g. 9 OR 6 = 4'hF); these are output as-is.
  - Reserved ST_L (5–7): number <= 16'h0000, set <= 0.
- Carry/borrow chains are combinational within one cycle: units → tens → hundreds → thousands.
- Mid-operation reset: the result register clears on that edge; the next non-reset edge behaves per the current ST.
- ST change S_OBL→S_WYN: the last computed result is frozen, and set stays 1.
- ST change to S_A or S_B: set drops to 0 on the next edge.

Test Plan:
- Reset then ST=S_OBL, A=0005, B=0001; step ST_L ADD,SUB,XOR,OR,AND one per cycle → number = 16'h0006, 16'h0004, 16'h0004, 16'h0005, 16'h0001 in successive cycles; set=1 from the first edge.
- Carry chain: S_OBL ADD, A=0999, B=0001 → 16'h1000; A=9999, B=0001 → 16'h0000 (wrap).
- Borrow chain: S_OBL SUB, A=1000, B=0001 → 16'h0999; A=0000, B=0001 → 16'h9999.
- Display states: ST=S_A, A=1234 → 16'h1234, set=0; ST=S_B, B=5678 → 16'h5678; digit A4=4'hC in S_A → units shows 9.
- Hold / reserved: compute ADD 0012+0030 (16'h0042), switch ST=S_WYN and change A → number stays 16'h0042, set=1; ST=S_OBL with ST_L=6 → 16'h0000, set=0.
- Reset priority: rst=1 while ST=S_OBL with nonzero result → next edge number=0, set=0; rst released → result reappears one cycle later.
